// File: rtl/nand_error_monitor.sv
// nand_error_monitor
//   Watches the registered output of a NAND stage under test, compares it
//   against a locally delayed golden NAND of the same operands, and counts
//   mismatches over a fixed window of WINDOW compared samples. Each finished
//   window is offered on a valid/ready result port. Accepting a result adds it
//   to a saturating running total.
//
// Ports
//   clk            clock, all state on rising edge
//   reset_n        asynchronous active-low reset
//   start_i        request a measurement (accepted only in IDLE)
//   x_i, y_i       operands, also driven to the gate under test
//   dut_z_i        registered output of the gate under test
//   busy_o         high in PRIME, COUNT and REPORT
//   result_valid_o result available, held until accepted
//   result_ready_i consumer accepts result when high with result_valid_o
//   err_count_o    mismatches in the last completed window
//   total_err_o    saturating sum of all accepted windows since reset
//   state_o        current FSM state (0 IDLE, 1 PRIME, 2 COUNT, 3 REPORT)
//
// Result handshake: a result transfers on a rising edge where result_valid_o
// and result_ready_i are both high. While result_ready_i is low,
// result_valid_o and err_count_o hold steady; result_valid_o never drops
// without a transfer except on reset.
module nand_error_monitor #(
  parameter int WINDOW       = 100,
  parameter int COUNT_WIDTH  = 7,
  parameter int TOTAL_WIDTH  = 16,
  parameter int GOLDEN_DELAY = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start_i,
  input  logic                   x_i,
  input  logic                   y_i,
  input  logic                   dut_z_i,
  output logic                   busy_o,
  output logic                   result_valid_o,
  input  logic                   result_ready_i,
  output logic [COUNT_WIDTH-1:0] err_count_o,
  output logic [TOTAL_WIDTH-1:0] total_err_o,
  output logic [1:0]             state_o
);

  generate
    if (WINDOW < 1) begin : g_bad_window
      $error("nand_error_monitor: WINDOW must be >= 1");
    end
    if (GOLDEN_DELAY < 1) begin : g_bad_delay
      $error("nand_error_monitor: GOLDEN_DELAY must be >= 1");
    end
    if (((64'd1 << COUNT_WIDTH) - 64'd1) < 64'(WINDOW)) begin : g_bad_count_width
      $error("nand_error_monitor: COUNT_WIDTH too small for WINDOW");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRIME  = 2'd1,
    S_COUNT  = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  // One counter serves both the PRIME duration and the sample count.
  localparam int CNT_MAX = (WINDOW > GOLDEN_DELAY) ? WINDOW : GOLDEN_DELAY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PRIME_LAST  = CNT_W'(GOLDEN_DELAY - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(WINDOW - 1);
  localparam int SUM_W = ((TOTAL_WIDTH > COUNT_WIDTH) ? TOTAL_WIDTH : COUNT_WIDTH) + 1;
  localparam logic [TOTAL_WIDTH-1:0] TOTAL_MAX = '1;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [COUNT_WIDTH-1:0]  work_err_q;
  logic [GOLDEN_DELAY-1:0] gline_q;

  logic                    mismatch;
  logic                    last_prime;
  logic                    last_sample;
  logic                    handshake;
  logic [COUNT_WIDTH-1:0]  work_err_inc;
  logic [SUM_W-1:0]        total_sum;
  logic [TOTAL_WIDTH-1:0]  total_next;

  // Golden line runs in every state so it is always aligned with the gate
  // register; it resets to 0 like the gate register does.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gline_q <= '0;
    end else begin
      gline_q[0] <= ~(x_i & y_i);
      for (int i = 1; i < GOLDEN_DELAY; i++) begin
        gline_q[i] <= gline_q[i-1];
      end
    end
  end

  assign mismatch     = dut_z_i ^ gline_q[GOLDEN_DELAY-1];
  assign last_prime   = (state_q == S_PRIME) && (cnt_q == PRIME_LAST);
  assign last_sample  = (state_q == S_COUNT) && (cnt_q == SAMPLE_LAST);
  assign handshake    = (state_q == S_REPORT) && result_ready_i;
  assign work_err_inc = work_err_q + COUNT_WIDTH'(mismatch);

  always_comb begin
    total_sum  = SUM_W'(total_err_o) + SUM_W'(err_count_o);
    total_next = (total_sum > SUM_W'(TOTAL_MAX)) ? TOTAL_MAX
                                                 : total_sum[TOTAL_WIDTH-1:0];
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i)     state_d = S_PRIME;
      S_PRIME:  if (last_prime)  state_d = S_COUNT;
      S_COUNT:  if (last_sample) state_d = S_REPORT;
      S_REPORT: if (handshake)   state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_o         = (state_q != S_IDLE);
    result_valid_o = (state_q == S_REPORT);
    state_o        = state_q;
  end

  // Counters and result registers. err_count_o is only written on REPORT
  // entry so a window in progress is never visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      work_err_q  <= '0;
      err_count_o <= '0;
      total_err_o <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            cnt_q      <= '0;
            work_err_q <= '0;
          end
        end
        S_PRIME: begin
          cnt_q <= last_prime ? '0 : cnt_q + CNT_W'(1);
        end
        S_COUNT: begin
          cnt_q      <= cnt_q + CNT_W'(1);
          work_err_q <= work_err_inc;
          if (last_sample) begin
            err_count_o <= work_err_inc;
          end
        end
        S_REPORT: begin
          if (result_ready_i) begin
            total_err_o <= total_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/nand_error_monitor.md
Name: nand_error_monitor

Overview:
- Downstream companion to the unreliable NAND stage. Observes the stage's registered output against a locally computed golden NAND of the same inputs and counts mismatches over a fixed sample window.
- Reports the empirical flip count per window, plus a saturating running total, through a valid/ready result handshake.
- Used by simulation benches and redundancy experiments to measure the effective error rate of a gate or a multiplexed gate bundle.

Parameters:
- WINDOW, 100, number of compared samples per measurement; must be >= 1.
- COUNT_WIDTH, 7, width of err_count_o; elaboration error if 2**COUNT_WIDTH - 1 < WINDOW.
- TOTAL_WIDTH, 16, width of total_err_o.
- GOLDEN_DELAY, 1, cycles between x_i/y_i and the matching dut_z_i; must be >= 1. The default matches the single output register of the gate.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start_i  input  1  request a measurement; accepted only in IDLE.
- x_i  input  1  first operand, same value driven to the gate under test.
- y_i  input  1  second operand, same value driven to the gate under test.
- dut_z_i  input  1  registered output of the gate under test.
- busy_o  input/output: output  1  high in PRIME, COUNT and REPORT.
- result_valid_o  output  1  result available; held until accepted.
- result_ready_i  input  1  consumer accepts result when high with result_valid_o.
- err_count_o  output  COUNT_WIDTH  mismatches in the last completed window.
- total_err_o  output  TOTAL_WIDTH  saturating sum of all reported windows since reset.

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE.
  - busy_o, result_valid_o, err_count_o, total_err_o, internal sample counter and golden delay line all clear to 0.
  - The golden line resetting to 0 matches the gate register's reset value.
- Golden path:
  - g = ~(x_i & y_i) shifts through a GOLDEN_DELAY-deep register line every cycle, in every state.
  - mismatch = dut_z_i ^ line tap [GOLDEN_DELAY-1].
- FSM:
  - IDLE:
    - start_i=1 -> PRIME.
    - Clears the working error counter and sample counter on entry to PRIME.
  - PRIME:
    - Lasts exactly GOLDEN_DELAY cycles, then -> COUNT.
    - No comparisons are made, so the first compared sample corresponds to the x_i/y_i presented in the first PRIME cycle.
  - COUNT:
    - Every cycle, compares one sample and increments the sample counter.
    - The working error counter increments on mismatch.
    - After the WINDOW-th sample -> REPORT, with the count including that final sample.
  - REPORT:
    - result_valid_o=1 and err_count_o = final window count, both stable while result_ready_i=0.
    - On the first valid&ready edge: total_err_o += err_count_o, saturating at 2**TOTAL_WIDTH-1. State -> IDLE, result_valid_o -> 0.
    - err_count_o keeps its value until the next REPORT entry.
- start_i is ignored outside IDLE, including in the cycle of handshake completion. A new start is accepted from the following cycle.
- Mismatches in the cycle after the last sample, or in PRIME/IDLE/REPORT, are never counted.
- err_count_o updates only on REPORT entry and is never partially visible.
- Reset asserted mid-PRIME/COUNT/REPORT aborts the measurement with no partial result, and clears total_err_o.
- Latency: start accepted at edge t -> result_valid_o high after edge t + GOLDEN_DELAY + WINDOW.

Test Plan:
- Clean gate: WINDOW=100, bench drives dut_z_i = golden (ERROR_PROBABILITY=0 stage), random x/y, start pulse -> result_valid_o after 101 cycles, err_count_o=0, total_err_o=0 after accept.
- Stuck-inverted gate: dut_z_i = ~golden for all cycles -> err_count_o=100; after accept total_err_o=100.
- Exact injection: flip samples 1, 50 and 100 plus the cycle after sample 100 -> err_count_o=3; flip during PRIME also uncounted.
- Backpressure: hold result_ready_i=0 for 5 cycles with start_i=1 throughout -> valid and count stable, no restart. Ready=1 with start=1 same cycle -> IDLE, start accepted next cycle, busy_o high again one cycle later.
- Reset mid-COUNT at sample 40 with 12 errors so far -> all outputs 0 immediately, IDLE. Next full clean window gives 0.
- Saturation: TOTAL_WIDTH=4, WINDOW=10, two all-inverted windows -> total_err_o 10 then 15 (saturated), err_count_o=10 both times.
